// File: rtl/bht_predictor.sv
`default_nettype none
// ============================================================================
// Module   : bht_predictor
// Brief    : Branch history table of 2-bit saturating counters with a
//            one-cycle registered lookup and a write-first update bypass.
//            Define BHT_GSHARE_EN to XOR a global history register into the
//            lookup index (gshare).
// Revision : 1.0  initial release
// ============================================================================
module bht_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    input  logic                  stall,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken
);

    localparam int         c_DEPTH     = 1 << INDEX_BITS;
    localparam logic [1:0] c_CNT_RESET = 2'b01;

    logic [1:0]            r_cnt [c_DEPTH];
    logic [1:0]            w_upd_old;
    logic [1:0]            w_upd_new;
    logic [1:0]            w_lkp_cnt;
    logic [INDEX_BITS-1:0] w_lkp_idx;
    logic                  w_unused_pc;

    // Only the word-index bits of the PC select an entry.
    assign w_unused_pc = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= {r_ghr[INDEX_BITS-2:0], upd_taken};
        end
    end

    // Lookup hashes with the history as it stands before this edge's shift.
    assign w_lkp_idx = lookup_pc[INDEX_BITS+1:2] ^ r_ghr;
`else
    assign w_lkp_idx = lookup_pc[INDEX_BITS+1:2];
`endif

    assign w_upd_old = r_cnt[upd_index];

    always_comb begin
        w_upd_new = w_upd_old;
        if (upd_taken) begin
            if (w_upd_old != 2'b11) w_upd_new = w_upd_old + 2'd1;
        end else begin
            if (w_upd_old != 2'b00) w_upd_new = w_upd_old - 2'd1;
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is forwarded.
    assign w_lkp_cnt = (upd_valid && (upd_index == w_lkp_idx)) ? w_upd_new
                                                               : r_cnt[w_lkp_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_cnt[i] <= c_CNT_RESET;
            end
        end else if (upd_valid) begin
            r_cnt[upd_index] <= w_upd_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else if (!stall) begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                pred_taken <= w_lkp_cnt[1];
                pred_index <= w_lkp_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 The module SHALL have parameter INDEX_BITS, default 6, giving log2 of the number of 2-bit counter entries (64 by default).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset; it SHALL be asynchronous and active-low.
REQ-004 The module SHALL have port lookup_valid, input, 1 bit, meaning a fetch PC is presented this cycle.
REQ-005 The module SHALL have port lookup_pc, input, 32 bits, the fetch PC (the same address the fetch stage gives the BTB).
REQ-006 The module SHALL have port stall, input, 1 bit, meaning hold the prediction outputs.
REQ-007 The module SHALL have port pred_valid, output, 1 bit, meaning pred_taken and pred_index are meaningful.
REQ-008 The module SHALL have port pred_taken, output, 1 bit, meaning the direction prediction; fetch SHALL select the BTB target only when pred_taken and btb_resp are both 1.
REQ-009 The module SHALL have port pred_index, output, INDEX_BITS bits, the table index used for this prediction, carried down the pipeline.
REQ-010 The module SHALL have port upd_valid, input, 1 bit, meaning a resolved conditional branch from EX.
REQ-011 The module SHALL have port upd_index, input, INDEX_BITS bits, the pred_index returned with the resolved branch.
REQ-012 The module SHALL have port upd_taken, input, 1 bit, the actual branch outcome.

Function
REQ-013 The table SHALL be 2^INDEX_BITS 2-bit saturating counters; prediction SHALL be counter bit 1 (10 or 11 = taken).
REQ-014 Lookup index, when no global history is used, SHALL be lookup_pc[INDEX_BITS+1:2].
REQ-015 Lookup latency SHALL be one cycle: on an edge with lookup_valid=1 and stall=0, pred_valid<=1 and pred_taken/pred_index<=counter value and index for lookup_pc.
REQ-016 On an edge with lookup_valid=0 and stall=0, pred_valid SHALL become 0; pred_taken and pred_index SHALL hold their values.
REQ-017 On an edge with stall=1, pred_valid, pred_taken and pred_index SHALL all hold their values; updates SHALL still be applied.
REQ-018 On an edge with upd_valid=1, counter[upd_index] SHALL increment if upd_taken=1 and decrement otherwise, saturating at 11 and 00.
REQ-019 Simultaneous lookup and update to the same index SHALL be write-first: pred_taken SHALL reflect the post-update counter value.
REQ-020 Updates to different indices in consecutive cycles SHALL all be applied; there SHALL be no update queueing or back-pressure.

Reset
REQ-021 While rst_n=0, every counter SHALL be 01 (weakly not-taken).
REQ-022 While rst_n=0, pred_valid, pred_taken and pred_index SHALL be 0.
REQ-023 While rst_n=0, the global history register (when present) SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight lookup or update in that cycle; the first edge after rst_n rises SHALL behave as from power-up.

Configuration
REQ-025 Macro BHT_GSHARE_EN, when defined, SHALL add an INDEX_BITS-wide global history register (ghr).
REQ-026 With BHT_GSHARE_EN defined, the lookup index SHALL be lookup_pc[INDEX_BITS+1:2] XOR ghr, and every upd_valid edge SHALL shift ghr left by one, inserting upd_taken at bit 0.
REQ-027 Without BHT_GSHARE_EN, no ghr SHALL exist and the index SHALL be per REQ-014; the port list SHALL be identical in both builds.

Verification (INDEX_BITS=6)
REQ-028 Reset, then lookup pc=0x00000040 -> next cycle pred_valid=1, pred_taken=0, pred_index=0x10.
REQ-029 Three updates idx 0x10 taken, then lookup 0x40 -> counter=11, pred_taken=1; four further not-taken updates -> counter=00 (saturated), pred_taken=0.
REQ-030 Counter at idx 0x10 = 01; same-cycle lookup 0x40 and update idx 0x10 taken -> pred_taken=1 (write-first bypass).
REQ-031 stall=1 for 3 cycles while lookup_pc changes -> pred_* outputs unchanged; an update issued during the stall is visible in the first lookup after stall=0.
REQ-032 BHT_GSHARE_EN build: updates taken, taken, not-taken -> ghr=0x06; then lookup 0x40 -> pred_index=0x16.
REQ-033 rst_n pulled low mid-run with a trained table -> all outputs read 0 immediately (asynchronous), and after release a lookup of any trained PC returns pred_taken=0.
